pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter: RESET_VECTOR, 64'd0, address loaded into the PC during BOOT.
REQ-003 Parameter: BOOT_CYCLES, 2, number of BOOT cycles, legal range 1..15.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  async active-high reset.
REQ-006 Port: pc_cur  input  64  current PC register output (pc_out).
REQ-007 Port: stall_req  input  1  load-use hazard stall request.
REQ-008 Port: mem_busy  input  1  multi-cycle instruction memory busy.
REQ-009 Port: branch_taken  input  1  EX-stage redirect request.
REQ-010 Port: branch_target  input  64  redirect address.
REQ-011 Port: trap_req  input  1  trap redirect request.
REQ-012 Port: trap_vector  input  64  trap handler address.
REQ-013 Port: pc_next  output  64  drives PC pc_in.
REQ-014 Port: pc_write  output  1  drives PC PCWrite.
REQ-015 Port: flush  output  1  IF/ID and ID/EX flush.
REQ-016 Port: stall_count  output  16  saturating count of STALL cycles.
REQ-017 Port: state  output  2  FSM state, for debug.

Function
REQ-018 The FSM SHALL have four states: BOOT=0, RUN=1, STALL=2, FLUSH=3.
REQ-019 pc_next, pc_write and flush SHALL be combinational from the state and inputs; the state, boot counter and stall_count SHALL be registered.
REQ-020 In BOOT, the block SHALL drive pc_write=1 and pc_next=RESET_VECTOR, ignore all request inputs, and go to RUN after BOOT_CYCLES cycles.
REQ-021 Priority in RUN and STALL SHALL be trap_req > branch_taken > (stall_req|mem_busy) > sequential.
REQ-022 On a redirect, the block SHALL drive pc_write=1 and pc_next=target with bits [1:0] forced to 0, drive flush=1, and go to FLUSH next.
REQ-023 On a stall, the block SHALL drive pc_write=0 and go to (or stay in) STALL.
REQ-024 On sequential flow, the block SHALL drive pc_write=1 and pc_next=pc_cur+4, wrapping modulo 2^64, and go to (or stay in) RUN.
REQ-025 FLUSH SHALL last one cycle with flush=1; trap_req and branch_taken SHALL be ignored in FLUSH; it SHALL go to STALL if a stall is requested, else advance sequentially and go to RUN.
REQ-026 A redirect SHALL override a simultaneous stall, because the stalled instruction is being squashed.
REQ-027 stall_count SHALL increment on every cycle that ends in STALL and saturate at 16'hFFFF.
REQ-028 At most one pc_write pulse per cycle SHALL reach the PC; pc_write SHALL never be X after reset.

Reset
REQ-029 Asserting reset SHALL immediately set state=BOOT, boot counter=0, stall_count=0 and flush=0, independent of clk.
REQ-030 Assertion mid-redirect or mid-stall SHALL abandon that operation with no pending redirect kept.
REQ-031 While reset is asserted, the outputs SHALL be pc_write=1 and pc_next=RESET_VECTOR, matching BOOT.

Configuration
REQ-032 With PC_SEQ_TRAP_EN defined, trap_req SHALL be honoured at the top priority.
REQ-033 Without PC_SEQ_TRAP_EN, the trap_req and trap_vector ports SHALL remain but be ignored, and the priority order SHALL start at branch_taken.

Structure
REQ-034 Package pc_seq_pkg SHALL hold the state enum, the PC_STEP=4 constant, the default RESET_VECTOR and the stall counter width of 16.
REQ-035 Sub-module sat_counter (16-bit, with inc and clr inputs) SHALL implement stall_count.
REQ-036 The bench SHALL instantiate pc_sequencer with the existing PC module connected in a loop.

Verification
REQ-037 Reset, then release with BOOT_CYCLES=2 -> state=BOOT for 2 cycles, then RUN, with pc_cur=0, 4, 8, ... on consecutive cycles.
REQ-038 stall_req=1 for 3 cycles at pc_cur=8 -> pc_write=0 and pc_cur holds at 8, stall_count=3, then pc_cur=12.
REQ-039 branch_taken=1 with branch_target=0x103 at pc_cur=16 -> next pc_cur=0x100, flush high for 2 cycles, and a branch during FLUSH is ignored.
REQ-040 branch_taken=1 together with mem_busy=1 -> redirect is taken and state=FLUSH.
REQ-041 With PC_SEQ_TRAP_EN defined, trap_req and branch_taken in the same cycle with trap_vector=0x200 -> pc_cur=0x200; without the macro -> pc_cur equals branch_target.
REQ-042 pc_cur=64'hFFFF_FFFF_FFFF_FFFC with sequential flow -> pc_next=0; reset asserted mid-STALL -> state=BOOT and stall_count=0 asynchronously.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared types and constants for the PC sequencer.
//   pc_state_t           : sequencer FSM state (BOOT=0, RUN=1, STALL=2, FLUSH=3)
//   PC_STEP              : sequential instruction stride in bytes
//   DEFAULT_RESET_VECTOR : default address loaded into the PC during BOOT
//   STALL_CNT_W          : width of the saturating stall counter
//   BOOT_CNT_W           : width of the boot cycle counter (BOOT_CYCLES 1..15)
//   align_target()       : clears bits [1:0] of a redirect address
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_FLUSH = 2'd3
   } pc_state_t;

   localparam logic [63:0] PC_STEP              = 64'd4;
   localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'd0;
   localparam int          STALL_CNT_W          = 16;
   localparam int          BOOT_CNT_W           = 4;

   // Instructions are word aligned; a redirect never lands mid-word.
   function automatic logic [63:0] align_target(input logic [63:0] addr);
      return {addr[63:2], 2'b00};
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- up counter that sticks at all-ones.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears count
//   inc   : add one this cycle (ignored once saturated)
//   clr   : synchronous clear, wins over inc
//   count : current value
module sat_counter
   import pc_seq_pkg::*;
#(
   parameter int W = STALL_CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- chooses the next PC and the write strobe for the PC register.
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   pc_cur         : current PC register value (fed back from the PC)
//   stall_req      : load-use hazard stall request
//   mem_busy       : instruction memory still busy
//   branch_taken   : EX-stage redirect, to branch_target
//   trap_req       : trap redirect, to trap_vector
//   pc_next        : value for the PC register input
//   pc_write       : PC register write enable
//   flush          : squash IF/ID and ID/EX
//   stall_count    : saturating count of cycles ending in STALL
//   state          : FSM state, for debug
// Build option: define PC_SEQ_TRAP_EN to honour trap_req above branch_taken;
// without it the trap ports exist but are ignored.
//
// Handshake: there is no valid/ready pair here. Requests are level inputs
// sampled every cycle; pc_write=1 means the PC register takes pc_next at
// the next rising edge, pc_write=0 means it holds.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [63:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int          BOOT_CYCLES  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [63:0]            pc_cur,
   input  logic                   stall_req,
   input  logic                   mem_busy,
   input  logic                   branch_taken,
   input  logic [63:0]            branch_target,
   input  logic                   trap_req,
   input  logic [63:0]            trap_vector,
   output logic [63:0]            pc_next,
   output logic                   pc_write,
   output logic                   flush,
   output logic [STALL_CNT_W-1:0] stall_count,
   output logic [1:0]             state
);

   localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_CYCLES - 1);

   pc_state_t             state_q, state_d;
   logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
   logic                  redirect_req;
   logic [63:0]           redirect_pc;
   logic                  stall_any;
   logic [63:0]           seq_pc;

`ifdef PC_SEQ_TRAP_EN
   assign redirect_req = trap_req | branch_taken;
   assign redirect_pc  = trap_req ? align_target(trap_vector)
                                  : align_target(branch_target);
`else
   logic unused_trap;
   assign unused_trap  = ^{trap_req, trap_vector};
   assign redirect_req = branch_taken;
   assign redirect_pc  = align_target(branch_target);
`endif

   assign stall_any = stall_req | mem_busy;
   assign seq_pc    = pc_cur + PC_STEP;   // wraps modulo 2^64
   assign state     = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_BOOT;
         boot_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      pc_next    = RESET_VECTOR;
      pc_write   = 1'b1;
      flush      = 1'b0;
      case (state_q)
         ST_BOOT: begin
            // Requests are ignored until the boot window has elapsed.
            if (boot_cnt_q == BOOT_LAST) begin
               state_d    = ST_RUN;
               boot_cnt_d = '0;
            end else begin
               boot_cnt_d = boot_cnt_q + 1'b1;
            end
         end
         ST_RUN, ST_STALL: begin
            // A redirect beats a stall: the stalled instruction is squashed.
            if (redirect_req) begin
               pc_next = redirect_pc;
               flush   = 1'b1;
               state_d = ST_FLUSH;
            end else if (stall_any) begin
               pc_next  = pc_cur;
               pc_write = 1'b0;
               state_d  = ST_STALL;
            end else begin
               pc_next = seq_pc;
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            // Redirects are ignored here; the wrong-path one is in flight.
            flush = 1'b1;
            if (stall_any) begin
               pc_next  = pc_cur;
               pc_write = 1'b0;
               state_d  = ST_STALL;
            end else begin
               pc_next = seq_pc;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d    = ST_BOOT;
            boot_cnt_d = '0;
         end
      endcase
   end

   sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (state_d == ST_STALL),
      .clr   (1'b0),
      .count (stall_count)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- pc_sequencer closed in a loop with a PC register.
// A cycle model predicts the sequencer outputs and the PC value; a compare
// process checks them every falling edge outside reset, and directed steps
// pin hand-computed values. Honours PC_SEQ_TRAP_EN like the design.
module tb_pc_sequencer;

   localparam logic [63:0] RV     = 64'd0;
   localparam int          BOOT_N = 2;
`ifdef PC_SEQ_TRAP_EN
   localparam logic [63:0] TRAP_EXP = 64'h200;
`else
   localparam logic [63:0] TRAP_EXP = 64'h404;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] pc_cur;
   logic        stall_req, mem_busy, branch_taken, trap_req;
   logic [63:0] branch_target, trap_vector;
   logic [63:0] pc_next;
   logic        pc_write, flush;
   logic [15:0] stall_count;
   logic [1:0]  state;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_VECTOR(RV), .BOOT_CYCLES(BOOT_N)) dut (
      .clk           (clk),
      .reset         (reset),
      .pc_cur        (pc_cur),
      .stall_req     (stall_req),
      .mem_busy      (mem_busy),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .trap_req      (trap_req),
      .trap_vector   (trap_vector),
      .pc_next       (pc_next),
      .pc_write      (pc_write),
      .flush         (flush),
      .stall_count   (stall_count),
      .state         (state)
   );

   // PC register closing the loop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_cur <= 64'd0;
      else if (pc_write) pc_cur <= pc_next;
   end

   // ---------------- scoreboard counters ----------------
   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int          m_boot_left;
   bit          m_in_flush, m_stalled;
   logic [15:0] m_stalls;
   logic [63:0] m_pc;

   function automatic bit want_redirect();
`ifdef PC_SEQ_TRAP_EN
      return trap_req || branch_taken;
`else
      return branch_taken;
`endif
   endfunction

   function automatic logic [63:0] redirect_addr();
      logic [63:0] a;
`ifdef PC_SEQ_TRAP_EN
      a = trap_req ? trap_vector : branch_target;
`else
      a = branch_target;
`endif
      return a - (a % 64'd4);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_boot_left <= BOOT_N;
         m_in_flush  <= 1'b0;
         m_stalled   <= 1'b0;
         m_stalls    <= 16'd0;
         m_pc        <= 64'd0;
      end else if (m_boot_left > 0) begin
         m_boot_left <= m_boot_left - 1;
         m_pc        <= RV;
      end else if (!m_in_flush && want_redirect()) begin
         m_pc       <= redirect_addr();
         m_in_flush <= 1'b1;
         m_stalled  <= 1'b0;
      end else if (stall_req || mem_busy) begin
         m_in_flush <= 1'b0;
         m_stalled  <= 1'b1;
         if (m_stalls != 16'hFFFF) m_stalls <= m_stalls + 16'd1;
      end else begin
         m_in_flush <= 1'b0;
         m_stalled  <= 1'b0;
         m_pc       <= m_pc + 64'd4;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [63:0] e_state, e_next;
      logic        e_flush, e_write;
      if (!reset) begin
         if (m_boot_left > 0) begin
            e_state = 0; e_flush = 0; e_write = 1; e_next = RV;
         end else if (m_in_flush) begin
            e_state = 3; e_flush = 1;
            e_write = !(stall_req || mem_busy);
            e_next  = m_pc + 64'd4;
         end else begin
            e_state = m_stalled ? 2 : 1;
            if (want_redirect()) begin
               e_flush = 1; e_write = 1; e_next = redirect_addr();
            end else begin
               e_flush = 0;
               e_write = !(stall_req || mem_busy);
               e_next  = m_pc + 64'd4;
            end
         end
         chk("cyc_state", state, e_state);
         chk("cyc_flush", flush, e_flush);
         chk("cyc_pc_write", pc_write, e_write);
         if (e_write) chk("cyc_pc_next", pc_next, e_next);
         chk("cyc_stall_count", stall_count, m_stalls);
         chk("cyc_pc_cur", pc_cur, m_pc);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall_req = 0; mem_busy = 0; branch_taken = 0; trap_req = 0;
      branch_target = 64'd0; trap_vector = 64'd0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1;
      idle_inputs();
      cycle();
      chk("rst_state", state, 0);
      chk("rst_pc_write", pc_write, 1);
      chk("rst_pc_next", pc_next, RV);
      chk("rst_flush", flush, 0);
      chk("rst_stall_count", stall_count, 0);
      cycle();
      reset = 1'b0;
      #1 chk("boot0_state", state, 0);
      cycle(); chk("boot1_state", state, 0);
      cycle(); chk("run_state", state, 1); chk("run_pc0", pc_cur, 64'd0);
      cycle(); chk("run_pc4", pc_cur, 64'd4);
      cycle(); chk("run_pc8", pc_cur, 64'd8);

      // three stall cycles at pc 8
      stall_req = 1;
      #1 chk("stall_write0", pc_write, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(); chk("stall_hold_pc", pc_cur, 64'd8);
      end
      chk("stall_count3", stall_count, 16'd3);
      chk("stall_state", state, 2);
      stall_req = 0;
      #1 chk("unstall_next", pc_next, 64'd12);
      cycle(); chk("unstall_pc12", pc_cur, 64'd12); chk("unstall_state", state, 1);
      cycle(); chk("run_pc16", pc_cur, 64'd16);

      // branch to 0x103 (aligned to 0x100); branch in FLUSH is ignored
      branch_taken = 1; branch_target = 64'h103;
      #1 chk("br_flush", flush, 1); chk("br_next", pc_next, 64'h100);
      chk("br_write", pc_write, 1);
      cycle(); chk("br_state_flush", state, 3); chk("br_pc", pc_cur, 64'h100);
      branch_target = 64'h500;
      #1 chk("br_flush2", flush, 1); chk("br_ignored_next", pc_next, 64'h104);
      branch_taken = 0;
      cycle(); chk("br_after_pc", pc_cur, 64'h104); chk("br_after_state", state, 1);

      // branch with mem_busy: redirect wins
      branch_taken = 1; branch_target = 64'h300; mem_busy = 1;
      #1 chk("brbusy_write", pc_write, 1);
      cycle(); chk("brbusy_state", state, 3); chk("brbusy_pc", pc_cur, 64'h300);
      branch_taken = 0;
      #1 chk("flush_busy_write", pc_write, 0);
      cycle(); chk("flush_to_stall", state, 2); chk("stall_count4", stall_count, 16'd4);
      mem_busy = 0;
      cycle(); chk("busy_done_pc", pc_cur, 64'h304);

      // trap and branch together
      trap_req = 1; trap_vector = 64'h200; branch_taken = 1; branch_target = 64'h404;
      cycle(); chk("trap_pc", pc_cur, TRAP_EXP); chk("trap_state", state, 3);
      idle_inputs();
      cycle();

      // wrap at the top of the address space
      branch_taken = 1; branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle(); chk("wrap_pc", pc_cur, 64'hFFFF_FFFF_FFFF_FFFC);
      branch_taken = 0;
      #1 chk("wrap_next", pc_next, 64'd0); chk("wrap_write", pc_write, 1);
      cycle(); chk("wrap_pc0", pc_cur, 64'd0);
      cycle(); chk("wrap_pc4", pc_cur, 64'd4);

      // reset in the middle of a stall, between clock edges
      stall_req = 1;
      cycle(); cycle();
      chk("pre_rst_state", state, 2); chk("pre_rst_count", stall_count, 16'd6);
      #2 reset = 1'b1;
      #1 chk("async_state", state, 0); chk("async_count", stall_count, 0);
      chk("async_flush", flush, 0); chk("async_write", pc_write, 1);
      chk("async_next", pc_next, RV);
      cycle();
      branch_taken = 1; branch_target = 64'h700;
      reset = 1'b0;
      #1 chk("boot_ignore_state", state, 0); chk("boot_ignore_write", pc_write, 1);
      chk("boot_ignore_flush", flush, 0);
      cycle(); chk("reboot1_state", state, 0);
      idle_inputs();
      cycle(); chk("reboot_run", state, 1); chk("reboot_pc0", pc_cur, 64'd0);
      cycle(); chk("reboot_pc4", pc_cur, 64'd4);
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
